// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes,
// instruction field positions and FSM state encoding.
package instr_sequencer_pkg;

  localparam int DEF_PC_W   = 8;
  localparam int DEF_DATA_W = 9;
  localparam int DEF_ADDR_W = 3;

  localparam int IR_W = 16;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_JZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int IR_OP_LSB   = 13;
  localparam int IR_DST_LSB  = 10;
  localparam int IR_SRC1_LSB = 7;
  localparam int IR_SRC2_LSB = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_RD_A   = 4'd3,
    ST_RD_B   = 4'd4,
    ST_CAP_B  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_WB     = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, operand read, execute and
// write-back around an external register file and combinational ALU.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [IR_W-1:0]   ir_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              cy,
  input  logic              zero,
  output logic              flag_cy,
  output logic              flag_z,
  output logic              halted
);

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc;
  logic [IR_W-1:0]   ir;

  logic [2:0]        op;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;

  assign op   = ir[IR_OP_LSB +: 3];
  assign dst  = ir[IR_DST_LSB +: ADDR_W];
  assign src1 = ir[IR_SRC1_LSB +: ADDR_W];
  assign src2 = ir[IR_SRC2_LSB +: ADDR_W];

  assign opcode    = op;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
      ST_FETCH:         if (imem_ack) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_NOP:  state_nxt = ST_FETCH;
          OP_JZ:   state_nxt = ST_FETCH;
          OP_LDI:  state_nxt = ST_WB;
          OP_HALT: state_nxt = ST_HALT;
          default: state_nxt = ST_RD_A;
        endcase
      end
      ST_RD_A:  state_nxt = ST_RD_B;
      ST_RD_B:  state_nxt = ST_CAP_B;
      ST_CAP_B: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WB;
      ST_WB:    state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are pure state decodes, so a reset clears them on the next cycle.
  always_comb begin
    imem_req = 1'b0;
    rf_rd    = 1'b0;
    rf_wr    = 1'b0;
    rf_addr  = '0;
    halted   = 1'b0;
    case (state)
      ST_FETCH: imem_req = 1'b1;
      ST_RD_A: begin
        rf_rd   = 1'b1;
        rf_addr = src1;
      end
      ST_RD_B: begin
        rf_rd   = 1'b1;
        rf_addr = src2;
      end
      ST_WB: begin
        rf_wr   = 1'b1;
        rf_addr = dst;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      A       <= '0;
      B       <= '0;
      data_in <= '0;
      flag_cy <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir <= ir_data;
            pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DECODE: begin
          if (op == OP_LDI) data_in <= ir[DATA_W-1:0];
          if (op == OP_JZ && flag_z) pc <= ir[PC_W-1:0];
        end
        // Register file returns read data one cycle after the strobe.
        ST_RD_B:  A <= data_out;
        ST_CAP_B: B <= data_out;
        ST_EXEC: begin
          data_in <= alu_out;
          flag_cy <= cy;
          flag_z  <= zero;
        end
        default: ;
      endcase
    end
  end

endmodule
